// File: rtl/servo_dispense_ctrl_pkg.sv
// Shared types and default timing for the coin-dispense servo controller.
package servo_dispense_ctrl_pkg;

  // Dispense sequencer states
  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StOpen,
    StClose
  } disp_state_e;

  // Defaults assume a 30 MHz clock and a 50 Hz servo refresh
  localparam int unsigned DefFrameTicks  = 600000;  // 20 ms frame
  localparam int unsigned DefClosedTicks = 30000;   // 1 ms pulse
  localparam int unsigned DefOpenTicks   = 60000;   // 2 ms pulse
  localparam int unsigned DefOpenFrames  = 25;
  localparam int unsigned DefCloseFrames = 25;

  // Bits needed to hold 0..v-1, never less than one
  function automatic int unsigned clog2_min1(int unsigned v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running servo refresh frame counter; flags the last clock of every frame.
module servo_frame_timer
  import servo_dispense_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_TICKS = DefFrameTicks,
  parameter int unsigned FcW         = clog2_min1(FRAME_TICKS)
) (
  input  logic           clk,
  input  logic           clr,
  output logic [FcW-1:0] fc_o,
  output logic           frame_tick_o
);

  localparam logic [FcW-1:0] FcLast = FcW'(FRAME_TICKS - 1);

  logic [FcW-1:0] fc_q, fc_d;

  // Wrap to zero after the last tick of the frame
  always_comb begin
    frame_tick_o = (fc_q == FcLast);
    fc_d         = frame_tick_o ? '0 : fc_q + 1'b1;
  end

  // Frame counter register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      fc_q <= '0;
    end else begin
      fc_q <= fc_d;
    end
  end

  assign fc_o = fc_q;

endmodule

// File: rtl/servo_dispense_ctrl.sv
// Coin dispenser: sequences open/close servo pulses per coin on one of four channels.
module servo_dispense_ctrl
  import servo_dispense_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_TICKS  = DefFrameTicks,
  parameter int unsigned CLOSED_TICKS = DefClosedTicks,
  parameter int unsigned OPEN_TICKS   = DefOpenTicks,
  parameter int unsigned OPEN_FRAMES  = DefOpenFrames,
  parameter int unsigned CLOSE_FRAMES = DefCloseFrames
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_chan,
  input  logic [3:0] req_count,
  input  logic       abort,
  output logic [3:0] pwm,
  output logic       busy,
  output logic       done,
  output logic [3:0] dispensed,
  output logic       frame_tick
);

  localparam int unsigned FcW = clog2_min1(FRAME_TICKS);
  localparam int unsigned PhW =
      clog2_min1((OPEN_FRAMES > CLOSE_FRAMES) ? OPEN_FRAMES : CLOSE_FRAMES);
  // One spare bit so a width equal to a full frame still fits
  localparam int unsigned WW  = FcW + 1;

  localparam logic [WW-1:0]  ClosedW   = WW'(CLOSED_TICKS);
  localparam logic [WW-1:0]  OpenW     = WW'(OPEN_TICKS);
  localparam logic [PhW-1:0] OpenLast  = PhW'(OPEN_FRAMES - 1);
  localparam logic [PhW-1:0] CloseLast = PhW'(CLOSE_FRAMES - 1);

  logic [FcW-1:0] fc;

  servo_frame_timer #(
    .FRAME_TICKS (FRAME_TICKS),
    .FcW         (FcW)
  ) u_timer (
    .clk          (clk),
    .clr          (clr),
    .fc_o         (fc),
    .frame_tick_o (frame_tick)
  );

  disp_state_e    state_q, state_d;
  logic [1:0]     chan_q, chan_d;
  logic [3:0]     count_q, count_d;
  logic [3:0]     disp_q, disp_d;
  logic           done_q, done_d;
  logic           abort_q, abort_d;
  logic [PhW-1:0] ph_q, ph_d;
  logic [WW-1:0]  width_q [4];
  logic [WW-1:0]  width_d [4];
  logic [3:0]     disp_inc;

  // Next-state logic for the sequencer, job bookkeeping and per-channel pulse widths
  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    count_d  = count_q;
    disp_d   = disp_q;
    done_d   = 1'b0;
    ph_d     = ph_q;
    width_d  = width_q;
    disp_inc = disp_q + 4'd1;
    // Abort is sticky only while a job is running; includes a pulse on this very cycle
    abort_d  = abort_q | (abort & (state_q != StIdle));

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          chan_d  = req_chan;
          count_d = req_count;
          disp_d  = '0;
          abort_d = 1'b0;
          if (req_count == 4'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = StArm;
          end
        end
      end
      StArm: begin
        // Wait for a frame boundary so the first open pulse is a whole frame
        if (frame_tick) begin
          ph_d = '0;
          if (abort_d) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StOpen;
          end
        end
      end
      StOpen: begin
        if (frame_tick) begin
          if (ph_q == OpenLast) begin
            state_d = StClose;
            ph_d    = '0;
          end else begin
            ph_d = ph_q + 1'b1;
          end
        end
      end
      StClose: begin
        if (frame_tick) begin
          if (ph_q == CloseLast) begin
            disp_d = disp_inc;
            ph_d   = '0;
            if ((disp_inc < count_q) && !abort_d) begin
              state_d = StOpen;
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end else begin
            ph_d = ph_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Widths only move on the frame boundary so every pulse starts clean at fc=0
    if (frame_tick) begin
      for (int i = 0; i < 4; i++) begin
        width_d[i] = ((state_d == StOpen) && (chan_q == 2'(i))) ? OpenW : ClosedW;
      end
    end
  end

  // Sequencer and width registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      chan_q  <= '0;
      count_q <= '0;
      disp_q  <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      ph_q    <= '0;
      for (int i = 0; i < 4; i++) begin
        width_q[i] <= ClosedW;
      end
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      count_q <= count_d;
      disp_q  <= disp_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      ph_q    <= ph_d;
      width_q <= width_d;
    end
  end

  // Pulse generation against the shared frame counter
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pwm[i] = ({1'b0, fc} < width_q[i]);
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign dispensed = disp_q;

endmodule

// File: tb/tb_servo_dispense_ctrl.sv
// Directed bench for servo_dispense_ctrl with short frames (100 clocks, 10/20 pulses, 2+2 frames).
module tb_servo_dispense_ctrl;

  logic       clk;
  logic       clr;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_chan;
  logic [3:0] req_count;
  logic       abort;
  logic [3:0] pwm;
  logic       busy;
  logic       done;
  logic [3:0] dispensed;
  logic       frame_tick;

  int vectors;
  int miscompares;
  int done_seen;
  int d0;
  int hi [4];

  servo_dispense_ctrl #(
    .FRAME_TICKS  (100),
    .CLOSED_TICKS (10),
    .OPEN_TICKS   (20),
    .OPEN_FRAMES  (2),
    .CLOSE_FRAMES (2)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_chan   (req_chan),
    .req_count  (req_count),
    .abort      (abort),
    .pwm        (pwm),
    .busy       (busy),
    .done       (done),
    .dispensed  (dispensed),
    .frame_tick (frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, noting any done pulse
  task automatic step();
    @(negedge clk);
    if (done === 1'b1) done_seen++;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // Run to the next last-clock-of-frame, bounded
  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (frame_tick !== 1'b1 && n < 200);
    check("frame_tick reached", int'(frame_tick), 1);
  endtask

  // Count high clocks per channel over n samples
  task automatic measure(input int n);
    for (int i = 0; i < 4; i++) hi[i] = 0;
    repeat (n) begin
      step();
      for (int i = 0; i < 4; i++) hi[i] += int'(pwm[i]);
    end
  endtask

  task automatic request(input logic [1:0] ch, input logic [3:0] cnt);
    req_chan  = ch;
    req_count = cnt;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    done_seen   = 0;
    clr         = 1'b1;
    req_valid   = 1'b0;
    req_chan    = 2'd0;
    req_count   = 4'd0;
    abort       = 1'b0;

    // Reset state
    step();
    check("rst busy", int'(busy), 0);
    check("rst pwm", int'(pwm), 15);
    check("rst done", int'(done), 0);
    check("rst dispensed", int'(dispensed), 0);
    clr = 1'b0;
    step();
    check("post-rst ready", int'(req_ready), 1);
    check("post-rst busy", int'(busy), 0);

    // Idle frames: every channel closed width
    wait_tick();
    d0 = done_seen;
    for (int f = 0; f < 3; f++) begin
      measure(100);
      for (int i = 0; i < 4; i++) check($sformatf("idle f%0d ch%0d", f, i), hi[i], 10);
      check("idle tick at frame end", int'(frame_tick), 1);
    end
    check("idle no done", done_seen - d0, 0);

    // chan 2, one coin, accepted on a frame_tick cycle: full ARM frame first
    d0 = done_seen;
    request(2'd2, 4'd1);
    check("c1 busy", int'(busy), 1);
    check("c1 ready low", int'(req_ready), 0);
    check("c1 fc0 pwm", int'(pwm), 15);
    measure(99);
    check("c1 arm frame ch2", hi[2], 9);
    for (int f = 0; f < 4; f++) begin
      measure(100);
      check($sformatf("c1 f%0d ch2", f), hi[2], (f < 2) ? 20 : 10);
      check($sformatf("c1 f%0d others", f), int'(hi[0] == 10 && hi[1] == 10 && hi[3] == 10), 1);
    end
    check("c1 busy before end", int'(busy), 1);
    step();
    check("c1 done", int'(done), 1);
    check("c1 dispensed", int'(dispensed), 1);
    check("c1 idle", int'(busy), 0);
    step();
    check("c1 done one cycle", int'(done), 0);
    check("c1 done count", done_seen - d0, 1);

    // count 0: immediate done, no job
    wait_tick();
    steps(5);
    d0 = done_seen;
    request(2'd1, 4'd0);
    check("c0 done", int'(done), 1);
    check("c0 busy", int'(busy), 0);
    check("c0 dispensed", int'(dispensed), 0);
    step();
    check("c0 done cleared", int'(done), 0);
    wait_tick();
    measure(100);
    check("c0 ch1 closed", hi[1], 10);
    check("c0 done count", done_seen - d0, 1);

    // count 3 on chan 0, accepted mid-frame
    wait_tick();
    steps(50);
    d0 = done_seen;
    request(2'd0, 4'd3);
    check("c3 busy", int'(busy), 1);
    wait_tick();
    for (int f = 0; f < 12; f++) begin
      measure(100);
      check($sformatf("c3 f%0d ch0", f), hi[0], ((f % 4) < 2) ? 20 : 10);
      check($sformatf("c3 f%0d others", f), int'(hi[1] == 10 && hi[2] == 10 && hi[3] == 10), 1);
      if ((f % 4) == 3) check($sformatf("c3 f%0d dispensed", f), int'(dispensed), f / 4);
    end
    step();
    check("c3 done", int'(done), 1);
    check("c3 dispensed", int'(dispensed), 3);
    check("c3 idle", int'(busy), 0);
    step();
    check("c3 done count", done_seen - d0, 1);

    // count 5 on chan 3, abort in the second OPEN, plus an ignored request
    wait_tick();
    steps(10);
    d0 = done_seen;
    request(2'd3, 4'd5);
    wait_tick();
    for (int f = 0; f < 5; f++) begin
      measure(100);
      check($sformatf("ab f%0d ch3", f), hi[3], ((f % 4) < 2) ? 20 : 10);
    end
    check("ab dispensed after coin1", int'(dispensed), 1);
    steps(30);
    abort     = 1'b1;
    req_chan  = 2'd1;
    req_count = 4'd0;
    req_valid = 1'b1;
    check("ab ready while busy", int'(req_ready), 0);
    step();
    abort     = 1'b0;
    req_valid = 1'b0;
    check("ab still busy", int'(busy), 1);
    check("ab ignored req no done", int'(done), 0);
    wait_tick();
    for (int f = 0; f < 2; f++) begin
      measure(100);
      check($sformatf("ab close f%0d ch3", f), hi[3], 10);
      check($sformatf("ab close f%0d ch1", f), hi[1], 10);
    end
    step();
    check("ab done", int'(done), 1);
    check("ab dispensed", int'(dispensed), 2);
    check("ab idle", int'(busy), 0);
    wait_tick();
    measure(100);
    check("ab no third coin", hi[3], 10);
    check("ab done count", done_seen - d0, 1);

    // abort while in ARM: back to idle at the frame boundary with nothing dispensed
    wait_tick();
    steps(20);
    d0 = done_seen;
    request(2'd0, 4'd2);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    wait_tick();
    step();
    check("arm-ab done", int'(done), 1);
    check("arm-ab dispensed", int'(dispensed), 0);
    check("arm-ab idle", int'(busy), 0);
    wait_tick();
    measure(100);
    check("arm-ab ch0 closed", hi[0], 10);
    check("arm-ab done count", done_seen - d0, 1);

    // clr during OPEN: job abandoned, no done, closed from next frame
    wait_tick();
    steps(30);
    d0 = done_seen;
    request(2'd1, 4'd2);
    wait_tick();
    measure(100);
    check("clr open ch1", hi[1], 20);
    steps(40);
    clr = 1'b1;
    step();
    check("clr busy", int'(busy), 0);
    check("clr done", int'(done), 0);
    check("clr dispensed", int'(dispensed), 0);
    check("clr pwm", int'(pwm), 15);
    clr = 1'b0;
    step();
    check("clr ready", int'(req_ready), 1);
    wait_tick();
    measure(100);
    for (int i = 0; i < 4; i++) check($sformatf("clr after ch%0d", i), hi[i], 10);
    check("clr no done", done_seen - d0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/servo_dispense_ctrl.md
SERVO_DISPENSE_CTRL -- requirements
Module: servo_dispense_ctrl

Interface
REQ-001 Parameter FRAME_TICKS, default 600000, clocks per servo refresh frame (20 ms at 30 MHz).
REQ-002 Parameter CLOSED_TICKS, default 30000, pulse width for closed position (1 ms).
REQ-003 Parameter OPEN_TICKS, default 60000, pulse width for open position (2 ms).
REQ-004 Parameter OPEN_FRAMES, default 25, frames held open per coin; CLOSE_FRAMES, default 25, frames held closed per coin.
REQ-005 clk  in  1  system clock; one clock domain, all logic on rising edge.
REQ-006 clr  in  1  reset; asynchronous, active-high.
REQ-007 req_valid  in  1  dispense request valid; req_ready  out  1  high only in IDLE.
REQ-008 req_chan  in  2  servo/coin channel 0..3; req_count  in  4  coins to dispense, 0..15.
REQ-009 abort  in  1  stop after the current coin completes its close phase.
REQ-010 pwm  out  4  servo pulse per channel; busy  out  1  high when not IDLE.
REQ-011 done  out  1  one-cycle completion pulse; dispensed  out  4  coins completed in current/last job.
REQ-012 frame_tick  out  1  high on the last clock of each frame.

Function
REQ-013 Frame counter fc SHALL count 0..FRAME_TICKS-1 and wrap to 0; frame_tick SHALL equal (fc == FRAME_TICKS-1).
REQ-014 pwm[i] SHALL equal (fc < width[i]); width[i] registers SHALL change only on frame_tick cycles, taking effect from fc=0.
REQ-015 Every channel not in OPEN SHALL use CLOSED_TICKS; only the latched channel in OPEN SHALL use OPEN_TICKS.
REQ-016 FSM states: IDLE, ARM, OPEN, CLOSE; busy = (state != IDLE).
REQ-017 Accept SHALL occur when req_valid && req_ready; latch chan and count, clear dispensed, clear abort flag.
REQ-018 Accept with req_count=0 SHALL stay IDLE and pulse done on the next cycle; no width change.
REQ-019 Accept with req_count>0 SHALL enter ARM; ARM SHALL go to OPEN on the next frame_tick.
REQ-020 OPEN SHALL last exactly OPEN_FRAMES full frames, then go to CLOSE on a frame_tick.
REQ-021 CLOSE SHALL last exactly CLOSE_FRAMES full frames; at its end dispensed SHALL increment by 1.
REQ-022 End of CLOSE: if coins remain and no abort pending, go to OPEN; else go to IDLE and pulse done the following cycle.
REQ-023 abort pulsed while busy SHALL set a sticky flag; in ARM the block SHALL go to IDLE at the next frame_tick with done and dispensed=0.
REQ-024 abort in OPEN or CLOSE SHALL not shorten the current phase; the coin in progress SHALL complete and count.
REQ-025 abort while IDLE SHALL be ignored; req_valid while busy SHALL be ignored (not queued).
REQ-026 Frame-phase counter SHALL be wide enough for max(OPEN_FRAMES, CLOSE_FRAMES); fc width SHALL be clog2(FRAME_TICKS).
REQ-027 A simultaneous accept and frame_tick SHALL enter ARM and wait for the following frame_tick (no zero-length ARM).

Reset
REQ-028 clr SHALL asynchronously force: state IDLE, fc=0, all width=CLOSED_TICKS, dispensed=0, done=0, abort flag=0.
REQ-029 During and after reset: busy=0, req_ready=1 after release, pwm=4'b1111 (fc=0 < CLOSED_TICKS).
REQ-030 clr mid-job SHALL abandon the job without a done pulse; servos return to closed width from the next frame.

Structure
REQ-031 Shared package SHALL hold the FSM state enum and default timing constants (FRAME_TICKS, CLOSED_TICKS, OPEN_TICKS, frame counts).
REQ-032 One sub-module, servo_frame_timer, SHALL own fc and frame_tick; FSM and width registers stay in the top.

Verification (bench parameters FRAME_TICKS=100, CLOSED_TICKS=10, OPEN_TICKS=20, OPEN_FRAMES=2, CLOSE_FRAMES=2)
REQ-033 Reset then idle 300 clocks -> all pwm high 10 clocks per 100, busy=0, done never.
REQ-034 Request chan=2 count=1 -> pwm[2] 20-clock pulses for 2 frames then 10-clock for 2 frames; done once; dispensed=1; other pwm always 10.
REQ-035 Request count=3 -> exactly 3 open/close cycles (12 frames after ARM), dispensed=3, one done pulse.
REQ-036 Request count=0 -> done one cycle after accept, busy stays 0, no 20-clock pulse.
REQ-037 Count=5, abort during 2nd OPEN -> 2nd coin completes, dispensed=2, done, IDLE; req_valid while busy gives req_ready=0 and no effect.
REQ-038 clr asserted during OPEN -> immediate IDLE, no done, next frame pwm[chan] back to 10 clocks.
